// File: rtl/shift_exec_ctrl.sv
// shift_exec_ctrl: multi-cycle sequencer for RV32I SLL/SRL/SRA.
// Accepts one shift request, shifts SHIFT_STEP bit positions per cycle and
// returns the result through a valid/ready response port. busy lets the
// pipeline stall while an operation is in flight.
//
// Handshake semantics (both ports): a transfer happens in a cycle where
// valid && ready are both high at the rising edge. The request side is
// sampled only at that edge. The response side holds resp_valid, result and
// resp_err stable until the transfer. Neither valid depends combinationally
// on the matching ready.
//
// SHIFT_STEP must be one of 1, 2, 4, 8, 16, 32.
module shift_exec_ctrl #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic        subSra,
  input  logic [31:0] aIn,
  input  logic [4:0]  shamt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err,
  output logic [31:0] result,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ILL = 2'd3
  } op_t;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  state_t      state, state_next;
  op_t         op, op_next;
  op_t         dec_op;
  logic [31:0] data, data_next;
  logic [5:0]  remaining, remaining_next;
  logic [31:0] result_q, result_next;
  logic [5:0]  step_n;
  logic [31:0] shifted;
  logic        accept;
  logic        resp_fire;

  // Handshake decodes; req_ready is combinational so a flush or reset in
  // the same cycle blocks acceptance.
  assign req_ready  = (state == S_IDLE) && !flush && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_DONE);
  assign resp_err   = (state == S_DONE) && (op == OP_ILL);
  assign resp_fire  = resp_valid && resp_ready;
  assign result     = result_q;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // Decode the incoming request into an operation class.
  always_comb begin
    dec_op = OP_ILL;
    if (funct3 == 3'b001) begin
      dec_op = OP_SLL;
    end else if (funct3 == 3'b101) begin
      dec_op = subSra ? OP_SRA : OP_SRL;
    end
  end

  // One shift step: never shift past the remaining amount on the last step.
  always_comb begin
    step_n  = (remaining < STEP) ? remaining : STEP;
    shifted = data;
    case (op)
      OP_SLL:  shifted = data << step_n;
      OP_SRL:  shifted = data >> step_n;
      OP_SRA:  shifted = 32'($signed(data) >>> step_n);
      default: shifted = data;
    endcase
  end

  // Next-state and datapath updates; flush overrides the state transition.
  always_comb begin
    state_next     = state;
    op_next        = op;
    data_next      = data;
    remaining_next = remaining;
    result_next    = result_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          op_next        = dec_op;
          data_next      = aIn;
          remaining_next = {1'b0, shamt};
          if ((shamt == 5'd0) || (dec_op == OP_ILL)) begin
            state_next  = S_DONE;
            result_next = (dec_op == OP_ILL) ? 32'd0 : aIn;
          end else begin
            state_next = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_next      = shifted;
        remaining_next = remaining - step_n;
        if (remaining_next == 6'd0) begin
          state_next  = S_DONE;
          result_next = shifted;
        end
      end
      S_DONE: begin
        if (resp_fire) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  // State and datapath registers; reset clears all visible state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= OP_SLL;
      data      <= 32'd0;
      remaining <= 6'd0;
      result_q  <= 32'd0;
    end else begin
      state     <= state_next;
      op        <= op_next;
      data      <= data_next;
      remaining <= remaining_next;
      result_q  <= result_next;
    end
  end

endmodule

// File: tb/tb_shift_exec_ctrl.sv
// Directed bench for shift_exec_ctrl: one instance with SHIFT_STEP=1 and one
// with SHIFT_STEP=4, sharing all inputs except req_valid.
module tb_shift_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid, req_valid4;
  logic [2:0]  funct3;
  logic        subSra;
  logic [31:0] aIn;
  logic [4:0]  shamt;
  logic        resp_ready;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] result;
  logic [1:0]  dbg_state;
  logic        req_ready4, resp_valid4, resp_err4, busy4;
  logic [31:0] result4;
  logic [1:0]  dbg_state4;

  logic        sel;
  logic        o_req_ready, o_resp_valid, o_resp_err, o_busy;
  logic [31:0] o_result;

  logic [32:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  shift_exec_ctrl #(.SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready), .funct3(funct3), .subSra(subSra), .aIn(aIn),
    .shamt(shamt), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_err(resp_err), .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  shift_exec_ctrl #(.SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid4),
    .req_ready(req_ready4), .funct3(funct3), .subSra(subSra), .aIn(aIn),
    .shamt(shamt), .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_err(resp_err4), .result(result4), .busy(busy4), .dbg_state(dbg_state4)
  );

  // Observed outputs of the currently selected instance.
  always_comb begin
    o_req_ready  = sel ? req_ready4  : req_ready;
    o_resp_valid = sel ? resp_valid4 : resp_valid;
    o_resp_err   = sel ? resp_err4   : resp_err;
    o_busy       = sel ? busy4       : busy;
    o_result     = sel ? result4     : result;
  end

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the inputs.
  task automatic issue(input logic s, input logic [2:0] f3, input logic sra,
                       input logic [31:0] a, input logic [4:0] sh, input logic [32:0] exp);
    sel    = s;
    funct3 = f3;
    subSra = sra;
    aIn    = a;
    shamt  = sh;
    if (s) req_valid4 = 1'b1;
    else   req_valid  = 1'b1;
    #1;
    check("req_ready_idle", o_req_ready, 1);
    exp_q.push_back(exp);
    tick();
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
    aIn        = ~a;
    shamt      = ~sh;
    funct3     = 3'b010;
    subSra     = ~sra;
    check("busy_after_accept", o_busy, 1);
  endtask

  // Wait for resp_valid and compare latency and payload against the queue.
  task automatic wait_resp(input string tag, input int exp_lat);
    int lat;
    logic [32:0] e;
    lat = 1;
    while (!o_resp_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_result"}, o_result, e[31:0]);
    check({tag, "_err"}, o_resp_err, e[32]);
  endtask

  // Complete the response handshake and confirm return to idle.
  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, o_resp_valid, 0);
    check({tag, "_ready_back"}, o_req_ready, 1);
    check({tag, "_busy_clr"}, o_busy, 0);
  endtask

  initial begin
    int seen;
    n_checks   = 0;
    n_pass     = 0;
    sel        = 1'b0;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
    funct3     = 3'b000;
    subSra     = 1'b0;
    aIn        = 32'd0;
    shamt      = 5'd0;
    resp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    #1;
    check("rel_req_ready", req_ready, 1);
    check("rel_req_ready4", req_ready4, 1);

    // SLL 1 by 31, one bit per cycle
    issue(0, 3'b001, 0, 32'h0000_0001, 5'd31, {1'b0, 32'h8000_0000});
    wait_resp("sll31", 32);
    finish_resp("sll31");

    // SRA and SRL of the sign bit by 4
    issue(0, 3'b101, 1, 32'h8000_0000, 5'd4, {1'b0, 32'hF800_0000});
    wait_resp("sra4", 5);
    finish_resp("sra4");
    issue(0, 3'b101, 0, 32'h8000_0000, 5'd4, {1'b0, 32'h0800_0000});
    wait_resp("srl4", 5);
    finish_resp("srl4");

    // Four bits per cycle: SRA by 5 takes two shift cycles
    issue(1, 3'b101, 1, 32'h8000_0000, 5'd5, {1'b0, 32'hFC00_0000});
    wait_resp("sra5_step4", 3);
    finish_resp("sra5_step4");
    issue(1, 3'b001, 0, 32'h0000_00FF, 5'd12, {1'b0, 32'h000F_F000});
    wait_resp("sll12_step4", 4);
    finish_resp("sll12_step4");
    sel = 1'b0;

    // Zero shift amount and illegal funct3
    issue(0, 3'b101, 0, 32'hDEAD_BEEF, 5'd0, {1'b0, 32'hDEAD_BEEF});
    wait_resp("shamt0", 1);
    finish_resp("shamt0");
    issue(0, 3'b000, 0, 32'hDEAD_BEEF, 5'd0, {1'b1, 32'h0000_0000});
    wait_resp("illegal", 1);
    finish_resp("illegal");

    // Backpressure: response held stable while resp_ready stays low
    issue(0, 3'b101, 1, 32'h1234_5678, 5'd3, {1'b0, 32'h0246_8ACF});
    wait_resp("bp", 4);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", resp_valid, 1);
      check("bp_result", result, 32'h0246_8ACF);
      check("bp_err", resp_err, 0);
      check("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    finish_resp("bp");

    // Flush during SHIFT discards the operation
    issue(0, 3'b001, 0, 32'h0000_0003, 5'd20, {1'b0, 32'h0030_0000});
    tick();
    flush = 1'b1;
    #1;
    check("flush_req_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_busy", busy, 0);
    check("flush_state", dbg_state, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    check("flush_no_resp", seen, 0);

    // Flush with a request present in IDLE: not accepted
    flush     = 1'b1;
    req_valid = 1'b1;
    aIn       = 32'h0000_00F0;
    shamt     = 5'd4;
    funct3    = 3'b101;
    #1;
    check("flush_idle_ready", req_ready, 0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle_busy", busy, 0);
    issue(0, 3'b101, 0, 32'h0000_00F0, 5'd4, {1'b0, 32'h0000_000F});
    wait_resp("after_flush", 5);
    finish_resp("after_flush");

    // Reset in the middle of SHIFT
    issue(0, 3'b001, 0, 32'h0000_0001, 5'd10, {1'b0, 32'h0000_0400});
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_ready", req_ready, 0);
    tick();
    exp_q.delete();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", resp_valid, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_err", resp_err, 0);
    check("rst_mid_ready_held", req_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_release", req_ready, 1);
    issue(0, 3'b101, 0, 32'hFFFF_FFFF, 5'd8, {1'b0, 32'h00FF_FFFF});
    wait_resp("srl8_after_rst", 9);
    finish_resp("srl8_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
